// File: rtl/dram_arbiter.sv
// Arbitrates the single data-memory port between the CPU (priority) and a debug/loader master.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module dram_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdin,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wdin,
  output logic [31:0] dbg_rd,
  output logic        dbg_ack,
  output logic [31:0] dram_adr,
  output logic [31:0] dram_wdin,
  output logic        dram_we,
  input  logic [31:0] dram_rd,
  output logic [31:0] stat_cpu_cnt,
  output logic [31:0] stat_dbg_cnt,
  output logic [31:0] stat_stall_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

  typedef enum logic {
    D_IDLE = 1'b0,
    D_ACK  = 1'b1
  } dstate_t;

  dstate_t       r_state;
  dstate_t       w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_nxt;
  logic [DW-1:0] r_dbg_rd;
  logic [DW-1:0] w_dbg_rd_nxt;
  logic          r_dbg_ack;
  logic          w_dbg_gnt;

  // State register; a reset drops any in-flight debug access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= D_IDLE;
      r_wait_cnt <= '0;
      r_dbg_rd   <= '0;
      r_dbg_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_dbg_rd   <= w_dbg_rd_nxt;
      r_dbg_ack  <= w_dbg_gnt;
    end
  end

  // Grant decision, port steering and next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_dbg_rd_nxt   = r_dbg_rd;
    w_dbg_gnt      = (r_state == D_IDLE) && dbg_req &&
                     (!cpu_req || (r_wait_cnt == MAX_W)) && !rst;
    dram_adr       = cpu_adr;
    dram_wdin      = cpu_wdin;
    dram_we        = cpu_we && cpu_req;
    cpu_stall      = w_dbg_gnt && cpu_req;

    if (w_dbg_gnt) begin
      dram_adr  = dbg_adr;
      dram_wdin = dbg_wdin;
      dram_we   = dbg_we;
    end

    case (r_state)
      D_IDLE: begin
        if (w_dbg_gnt) begin
          w_dbg_rd_nxt   = dram_rd;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = D_ACK;
        end else if (dbg_req) begin
          if (r_wait_cnt < MAX_W) begin
            w_wait_cnt_nxt = r_wait_cnt + CW'(1);
          end
        end else begin
          w_wait_cnt_nxt = '0;
        end
      end
      D_ACK: begin
        w_state_nxt = D_IDLE;
      end
      default: begin
        w_state_nxt = D_IDLE;
      end
    endcase
  end

  assign cpu_rd  = dram_rd;
  assign dbg_rd  = r_dbg_rd;
  assign dbg_ack = r_dbg_ack;

`ifdef ARB_STATS_EN
  logic [DW-1:0] r_stat_cpu_cnt;
  logic [DW-1:0] r_stat_dbg_cnt;
  logic [DW-1:0] r_stat_stall_cnt;

  // Free-running wrap-around usage counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_cpu_cnt   <= '0;
      r_stat_dbg_cnt   <= '0;
      r_stat_stall_cnt <= '0;
    end else begin
      if (cpu_req && !cpu_stall) r_stat_cpu_cnt <= r_stat_cpu_cnt + DW'(1);
      if (w_dbg_gnt)             r_stat_dbg_cnt <= r_stat_dbg_cnt + DW'(1);
      if (cpu_stall)             r_stat_stall_cnt <= r_stat_stall_cnt + DW'(1);
    end
  end

  assign stat_cpu_cnt   = r_stat_cpu_cnt;
  assign stat_dbg_cnt   = r_stat_dbg_cnt;
  assign stat_stall_cnt = r_stat_stall_cnt;
`else
  assign stat_cpu_cnt   = '0;
  assign stat_dbg_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios then random traffic against a cycle-level
// reference model of the arbitration rules and a shadow copy of memory.
module tb_dram_arbiter;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_adr, cpu_wdin, cpu_rd;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_adr, dbg_wdin, dbg_rd;
  logic        dbg_ack;
  logic [31:0] dram_adr, dram_wdin, dram_rd;
  logic        dram_we;
  logic [31:0] stat_cpu_cnt, stat_dbg_cnt, stat_stall_cnt;

  always #5 clk = ~clk;

  dram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdin(cpu_wdin),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wdin(dbg_wdin),
    .dbg_rd(dbg_rd), .dbg_ack(dbg_ack),
    .dram_adr(dram_adr), .dram_wdin(dram_wdin), .dram_we(dram_we), .dram_rd(dram_rd),
    .stat_cpu_cnt(stat_cpu_cnt), .stat_dbg_cnt(stat_dbg_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  // DRAM: combinational read, write on the falling edge.
  bit [31:0] dram_mem [256];
  assign dram_rd = dram_mem[dram_adr[9:2]];
  always @(negedge clk) if (dram_we) dram_mem[dram_adr[9:2]] <= dram_wdin;

  // Reference model state: the values the registered outputs must show this cycle.
  bit [31:0]   ref_mem [256];
  bit          m_ack;
  int unsigned m_waited;
  logic [31:0] m_dbg_rd;
  logic [31:0] m_cpu_cnt, m_dbg_cnt, m_stall_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic creq, input logic cwe,
                       input logic [31:0] cadr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe,
                       input logic [31:0] dadr, input logic [31:0] dwd);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_adr = cadr; cpu_wdin = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_adr = dadr; dbg_wdin = dwd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare everything against the model for the current cycle, then advance the model.
  task automatic check_model();
    bit          gnt;
    bit          e_we;
    bit          e_stall;
    logic [31:0] e_adr, e_wd;
    logic [31:0] e_s_cpu, e_s_dbg, e_s_stall;
    gnt     = !m_ack && dbg_req && (!cpu_req || m_waited >= MAX_WAIT) && !rst;
    e_adr   = gnt ? dbg_adr  : cpu_adr;
    e_wd    = gnt ? dbg_wdin : cpu_wdin;
    e_we    = gnt ? dbg_we   : (cpu_we && cpu_req);
    e_stall = gnt && cpu_req;
`ifdef ARB_STATS_EN
    e_s_cpu = m_cpu_cnt; e_s_dbg = m_dbg_cnt; e_s_stall = m_stall_cnt;
`else
    e_s_cpu = 32'h0; e_s_dbg = 32'h0; e_s_stall = 32'h0;
`endif
    chk("dram_adr",  dram_adr, e_adr);
    chk("dram_wdin", dram_wdin, e_wd);
    chk("dram_we",   32'(dram_we), 32'(e_we));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("cpu_rd",    cpu_rd, ref_mem[e_adr[9:2]]);
    chk("dbg_ack",   32'(dbg_ack), 32'(m_ack));
    chk("dbg_rd",    dbg_rd, m_dbg_rd);
    chk("stat_cpu",   stat_cpu_cnt, e_s_cpu);
    chk("stat_dbg",   stat_dbg_cnt, e_s_dbg);
    chk("stat_stall", stat_stall_cnt, e_s_stall);

    if (e_we) ref_mem[e_adr[9:2]] = e_wd;
    if (rst) begin
      m_ack = 0; m_waited = 0; m_dbg_rd = 32'h0;
      m_cpu_cnt = 32'h0; m_dbg_cnt = 32'h0; m_stall_cnt = 32'h0;
    end else begin
      if (gnt) m_dbg_rd = ref_mem[dbg_adr[9:2]];
      if (!m_ack) begin
        if (gnt) m_waited = 0;
        else if (dbg_req) m_waited = (m_waited + 1 > MAX_WAIT) ? MAX_WAIT : m_waited + 1;
        else m_waited = 0;
      end
      if (cpu_req && !e_stall) m_cpu_cnt = m_cpu_cnt + 32'd1;
      if (gnt) m_dbg_cnt = m_dbg_cnt + 32'd1;
      if (e_stall) m_stall_cnt = m_stall_cnt + 32'd1;
      m_ack = gnt;
    end
  endtask

  initial begin
    bit          pend;
    logic        p_we;
    logic [31:0] p_adr, p_wd;
    logic [31:0] old20;

    m_ack = 0; m_waited = 0; m_dbg_rd = 32'h0;
    m_cpu_cnt = 32'h0; m_dbg_cnt = 32'h0; m_stall_cnt = 32'h0;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdin = 0;
    dbg_req = 0; dbg_we = 0; dbg_adr = 0; dbg_wdin = 0;
    step();

    // Reset: a debug request is never granted, CPU still drives DRAM.
    drive(1, 1, 1, 32'h40, 32'h55, 1, 1, 32'h10, 32'h99);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_ack", 32'(dbg_ack), 32'h0);
    check_model(); step();

    // Debug write then read back with idle CPU.
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    chk("t1_we", 32'(dram_we), 32'h1);
    check_model(); step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("t1_ack", 32'(dbg_ack), 32'h1);
    check_model(); step();
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    check_model(); step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("t1_rd", dbg_rd, 32'hDEADBEEF);
    chk("t1_rdack", 32'(dbg_ack), 32'h1);
    check_model(); step();

    // Worst-case latency under continuous CPU reads; request still high during the ack cycle.
    for (int c = 1; c <= 7; c++) begin
      drive(0, 1, 0, 32'h40 + 32'(4 * c), 32'h0, c <= 6, 0, 32'h10, 32'h0);
      if (c <= 4) chk("lat_cpu_first", 32'(cpu_stall), 32'h0);
      if (c == 5) begin
        chk("lat_stall5", 32'(cpu_stall), 32'h1);
        chk("lat_adr5", dram_adr, 32'h10);
      end
      if (c == 6) begin
        chk("lat_ack6", 32'(dbg_ack), 32'h1);
        chk("lat_nostall6", 32'(cpu_stall), 32'h0);
      end
      check_model(); step();
    end

    // CPU write blocked by a forced debug grant, then retried.
    old20 = dram_mem[8];
    for (int c = 1; c <= 7; c++) begin
      if (c == 6) chk("t3_blocked", dram_mem[8], old20);
      if (c == 7) chk("t3_retry", dram_mem[8], 32'h1234);
      drive(0, c <= 6, c >= 5, (c >= 5) ? 32'h20 : 32'h80, 32'h1234,
            c <= 5, 0, 32'h30, 32'h0);
      check_model(); step();
    end

    // Withdrawn request: no access, no ack, and the wait budget restarts.
    for (int c = 1; c <= 12; c++) begin
      drive(0, 1, 0, 32'h44, 32'h0, (c <= 2) || (c >= 5 && c <= 9), 1, 32'h50, 32'hA5A5);
      if (c >= 3 && c <= 5) chk("t4_noack", 32'(dbg_ack), 32'h0);
      if (c == 8) chk("t4_restart", 32'(cpu_stall), 32'h0);
      if (c == 9) chk("t4_grant", 32'(cpu_stall), 32'h1);
      check_model(); step();
    end

    // Reset during the ack cycle.
    drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h60, 32'h77);
    check_model(); step();
    drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_model(); step();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("t5_ack", 32'(dbg_ack), 32'h0);
    chk("t5_dbgcnt", stat_dbg_cnt, 32'h0);
    chk("t5_dbgrd", dbg_rd, 32'h0);
    check_model(); step();

    // Random traffic with a well-behaved debug master.
    pend = 0; p_we = 0; p_adr = 0; p_wd = 0;
    for (int n = 0; n < 800; n++) begin
      if (dbg_ack) pend = 0;
      if (!pend && ($urandom % 4 == 0)) begin
        pend  = 1;
        p_we  = 1'($urandom % 2);
        p_adr = {22'h0, 8'($urandom % 16), 2'b00};
        p_wd  = $urandom;
      end else if (pend && ($urandom % 25 == 0)) begin
        pend = 0;
      end
      drive(($urandom % 60) == 0, ($urandom % 10) < 7, 1'($urandom % 2),
            {22'h0, 8'($urandom % 16), 2'b00}, $urandom, pend, p_we, p_adr, p_wd);
      check_model(); step();
    end

    for (int i = 0; i < 16; i++) chk("mem_final", dram_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single data-memory port between the miniCPU data port and a debug/loader master (e.g. UART memory loader or bench backdoor). The CPU has priority, and the debug master is guaranteed service after a bounded wait. The winner's request is steered to the DRAM each cycle; the CPU is stalled only in cycles the debug master wins. The block sits between the CPU data port, the debug master and the DRAM, clocked on the CPU clock.

## Interface
Parameters:
- MAX_WAIT, 4: cycles a pending debug request may lose to the CPU before it is forced through. Legal range 1..15.

Ports:
- clk  in  1  CPU clock, single clock domain.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU data access this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_adr  in  32  CPU byte address.
- cpu_wdin  in  32  CPU write data.
- cpu_rd  out  32  read data to CPU; equals dram_rd.
- cpu_stall  out  1  combinational; CPU must hold its access this cycle.
- dbg_req  in  1  debug request; held with stable adr/we/wdin until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_adr  in  32  debug byte address.
- dbg_wdin  in  32  debug write data.
- dbg_rd  out  32  registered read data for the debug master.
- dbg_ack  out  1  registered one-cycle completion pulse.
- dram_adr  out  32  to DRAM.
- dram_wdin  out  32  to DRAM.
- dram_we  out  1  to DRAM.
- dram_rd  in  32  combinational DRAM read data.
- stat_cpu_cnt  out  32  CPU grant count.
- stat_dbg_cnt  out  32  debug grant count.
- stat_stall_cnt  out  32  CPU stall cycle count.

## Operation
- Debug FSM states: D_IDLE and D_ACK. Wait counter wait_cnt is 4 bits, saturating at MAX_WAIT.
- Grant decision (combinational):
  - dbg_gnt = (state==D_IDLE) & dbg_req & (~cpu_req | wait_cnt==MAX_WAIT) & ~rst.
  - Otherwise the CPU owns the port.
- Steering:
  - On dbg_gnt, dram_adr/wdin come from dbg_* and dram_we = dbg_we.
  - Otherwise they come from cpu_*, and dram_we = cpu_we & cpu_req.
- cpu_stall = dbg_gnt & cpu_req. A stalled CPU write never reaches DRAM.
- D_IDLE transitions:
  - On dbg_gnt: capture dram_rd into dbg_rd (reads and writes alike), clear wait_cnt, go to D_ACK.
  - On dbg_req & ~dbg_gnt: wait_cnt increments, saturating.
  - On ~dbg_req: wait_cnt clears. A request withdrawn before grant is aborted silently, with no access and no ack.
- D_ACK: dbg_ack=1 for exactly this cycle and the CPU has exclusive access. The state always returns to D_IDLE. dbg_req still high in the following D_IDLE cycle is a new request.
- Worst-case debug latency under continuous CPU traffic: the access occurs in cycle MAX_WAIT+1 of the request (cycle 1 = first request cycle), and the ack follows one cycle later.
- Reset mid-transaction: the FSM is forced to D_IDLE and the in-flight debug access is dropped with no ack. The debug master must re-issue it.

## Timing
- Reset values:
  - state=D_IDLE, wait_cnt=0, dbg_ack=0, dbg_rd=0, stat_* counters=0.
  - During rst: cpu_stall=0, and the DRAM is steered from the CPU with dram_we = cpu_we & cpu_req.
- CPU path is zero-latency combinational: cpu_rd is valid in the request cycle and the write commits on the DRAM's (inverted-clock) edge of that cycle.
- Debug path:
  - Access in the grant cycle N.
  - dbg_ack and dbg_rd valid in cycle N+1.
  - dbg_rd holds its value until the next debug grant.
- Simultaneous requests with wait_cnt<MAX_WAIT: the CPU wins, no stall, and wait_cnt increments.

## Configuration
- ARB_STATS_EN defined:
  - stat_cpu_cnt increments on every cycle with cpu_req & ~cpu_stall.
  - stat_dbg_cnt increments on every dbg_gnt.
  - stat_stall_cnt increments on every cpu_stall cycle.
  - All three are 32-bit, wrap at 2^32, and clear on rst.
- ARB_STATS_EN undefined: stat_* ports remain but are tied to 32'h0, and no counter logic is synthesized.

## Test plan
- Debug only: dbg_req=1, dbg_we=1, dbg_adr=0x10, dbg_wdin=0xDEADBEEF, cpu_req=0 -> dram_we=1 in the same cycle; dbg_ack one cycle later. A following debug read of 0x10 -> dbg_rd=0xDEADBEEF with ack.
- Continuous CPU traffic plus a debug read with MAX_WAIT=4 -> CPU served in cycles 1-4 with cpu_stall=0. Cycle 5: cpu_stall=1 and dram_adr=dbg_adr. Cycle 6: dbg_ack=1, no stall.
- CPU write during a forced debug grant (cpu_we=1, cpu_adr=0x20, value 0x1234) -> DRAM[0x20] is unchanged that cycle. The CPU retries next cycle and DRAM[0x20]=0x1234.
- Debug request withdrawn after 2 waiting cycles -> no dram access from dbg, dbg_ack never asserts, wait_cnt back to 0.
- rst asserted in the D_ACK cycle -> next cycle dbg_ack=0, state D_IDLE, all stat_* =0. With ARB_STATS_EN undefined, stat_* read 0 throughout.
